// File: rtl/scr1_imem_dmem_arbiter_if.sv
// Bundle of the imem, dmem and shared memory-port signals around the arbiter.
// The master modport is the arbiter's view; slave is the core-plus-memory side.
interface scr1_imem_dmem_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              imem_req_ack;
    logic              imem_req;
    logic [AWIDTH-1:0] imem_addr;
    logic [DWIDTH-1:0] imem_rdata;
    logic [1:0]        imem_resp;

    logic              dmem_req_ack;
    logic              dmem_req;
    logic              dmem_cmd;
    logic [1:0]        dmem_width;
    logic [AWIDTH-1:0] dmem_addr;
    logic [DWIDTH-1:0] dmem_wdata;
    logic [DWIDTH-1:0] dmem_rdata;
    logic [1:0]        dmem_resp;

    logic              port_req_ack;
    logic              port_req;
    logic              port_cmd;
    logic [1:0]        port_width;
    logic [AWIDTH-1:0] port_addr;
    logic [DWIDTH-1:0] port_wdata;
    logic [DWIDTH-1:0] port_rdata;
    logic [1:0]        port_resp;

    modport master (
        output imem_req_ack, imem_rdata, imem_resp,
        output dmem_req_ack, dmem_rdata, dmem_resp,
        output port_req, port_cmd, port_width, port_addr, port_wdata,
        input  imem_req, imem_addr,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  port_req_ack, port_rdata, port_resp
    );

    modport slave (
        input  imem_req_ack, imem_rdata, imem_resp,
        input  dmem_req_ack, dmem_rdata, dmem_resp,
        input  port_req, port_cmd, port_width, port_addr, port_wdata,
        output imem_req, imem_addr,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output port_req_ack, port_rdata, port_resp
    );
endinterface

// File: rtl/scr1_imem_dmem_arbiter.sv
// Round-robin (or dmem-priority) arbiter sharing one SCR1 memory port between
// imem and dmem, with zero added latency and pipelined address/data phases.
module scr1_imem_dmem_arbiter #(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter bit DMEM_PRIO = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    scr1_imem_dmem_arbiter_if.master      bus
);
    localparam logic [1:0] RESP_NOTRDY = 2'b00;
    localparam logic [1:0] RESP_RDY_OK = 2'b01;
    localparam logic       CMD_RD      = 1'b0;
    localparam logic [1:0] WIDTH_WORD  = 2'b10;

    typedef enum logic { ST_ADDR, ST_DATA } state_e;
    typedef enum logic { MST_IMEM = 1'b0, MST_DMEM = 1'b1 } master_e;

    state_e  state, state_nxt;
    master_e owner, owner_nxt;
    master_e last_gnt, last_gnt_nxt;
    master_e gnt;

    logic              window;
    logic              gnt_req;
    logic              accept;
    logic              imem_sel;
    logic              dmem_sel;
    logic [AWIDTH-1:0] gnt_addr;
    logic [DWIDTH-1:0] gnt_wdata;

    // A new address phase may overlap the RDY_OK of the outstanding one.
    assign window = (state == ST_ADDR) || (bus.port_resp == RESP_RDY_OK);

    always_comb begin
        gnt = MST_IMEM;
        if (bus.dmem_req && !bus.imem_req) begin
            gnt = MST_DMEM;
        end else if (bus.dmem_req && bus.imem_req) begin
            gnt = (DMEM_PRIO || last_gnt == MST_IMEM) ? MST_DMEM : MST_IMEM;
        end
    end

    assign gnt_req          = (gnt == MST_DMEM) ? bus.dmem_req : bus.imem_req;
    assign bus.port_req     = window && gnt_req;
    assign bus.imem_req_ack = window && (gnt == MST_IMEM) && bus.port_req_ack;
    assign bus.dmem_req_ack = window && (gnt == MST_DMEM) && bus.port_req_ack;
    assign accept           = bus.port_req && bus.port_req_ack;

    assign gnt_addr       = (gnt == MST_DMEM) ? bus.dmem_addr : bus.imem_addr;
    assign gnt_wdata      = (gnt == MST_DMEM) ? bus.dmem_wdata : '0;
    assign bus.port_addr  = gnt_addr;
    assign bus.port_wdata = gnt_wdata;
    assign bus.port_cmd   = (gnt == MST_DMEM) ? bus.dmem_cmd : CMD_RD;
    assign bus.port_width = (gnt == MST_DMEM) ? bus.dmem_width : WIDTH_WORD;

    assign imem_sel = (state == ST_DATA) && (owner == MST_IMEM);
    assign dmem_sel = (state == ST_DATA) && (owner == MST_DMEM);

    assign bus.imem_resp  = imem_sel ? bus.port_resp : RESP_NOTRDY;
    assign bus.imem_rdata = imem_sel ? bus.port_rdata : '0;
    assign bus.dmem_resp  = dmem_sel ? bus.port_resp : RESP_NOTRDY;
    assign bus.dmem_rdata = dmem_sel ? bus.port_rdata : '0;

    // NOTE: every next-state variable gets its hold value first, so no path
    // through this block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_gnt_nxt = last_gnt;
        if (accept) begin
            state_nxt    = ST_DATA;
            owner_nxt    = gnt;
            last_gnt_nxt = gnt;
        end else if (state == ST_DATA && bus.port_resp != RESP_NOTRDY) begin
            state_nxt = ST_ADDR;
        end
    end

    // NOTE: state registers use non-blocking assignments so all three update
    // together from values computed before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ADDR;
            owner    <= MST_IMEM;
            last_gnt <= MST_DMEM;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end
endmodule

// File: tb/tb_scr1_imem_dmem_arbiter.sv
// Directed bench for scr1_imem_dmem_arbiter: round-robin and dmem-priority
// instances share stimulus and are checked every cycle against a bench model.
module tb_scr1_imem_dmem_arbiter;
    localparam logic [1:0] NRDY = 2'b00;
    localparam logic [1:0] OK   = 2'b01;
    localparam logic [1:0] ER   = 2'b10;

    typedef struct packed {
        logic        imem_req_ack;
        logic        dmem_req_ack;
        logic        port_req;
        logic        port_cmd;
        logic [1:0]  port_width;
        logic [31:0] port_addr;
        logic [31:0] port_wdata;
        logic [31:0] imem_rdata;
        logic [1:0]  imem_resp;
        logic [31:0] dmem_rdata;
        logic [1:0]  dmem_resp;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        dmem_req;
    logic        dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        port_req_ack;
    logic [1:0]  port_resp;
    logic [31:0] port_rdata;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: outstanding owner (-1 none, 0 imem, 1 dmem) and last winner.
    int own_m[2]  = '{-1, -1};
    int last_m[2] = '{1, 1};

    scr1_imem_dmem_arbiter_if b0 ();
    scr1_imem_dmem_arbiter_if b1 ();

    scr1_imem_dmem_arbiter #(.DMEM_PRIO(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
    scr1_imem_dmem_arbiter #(.DMEM_PRIO(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

    assign b0.imem_req = imem_req;       assign b1.imem_req = imem_req;
    assign b0.imem_addr = imem_addr;     assign b1.imem_addr = imem_addr;
    assign b0.dmem_req = dmem_req;       assign b1.dmem_req = dmem_req;
    assign b0.dmem_cmd = dmem_cmd;       assign b1.dmem_cmd = dmem_cmd;
    assign b0.dmem_width = dmem_width;   assign b1.dmem_width = dmem_width;
    assign b0.dmem_addr = dmem_addr;     assign b1.dmem_addr = dmem_addr;
    assign b0.dmem_wdata = dmem_wdata;   assign b1.dmem_wdata = dmem_wdata;
    assign b0.port_req_ack = port_req_ack; assign b1.port_req_ack = port_req_ack;
    assign b0.port_resp = port_resp;     assign b1.port_resp = port_resp;
    assign b0.port_rdata = port_rdata;   assign b1.port_rdata = port_rdata;

    out_t act0, act1;
    assign act0 = {b0.imem_req_ack, b0.dmem_req_ack, b0.port_req, b0.port_cmd, b0.port_width,
                   b0.port_addr, b0.port_wdata, b0.imem_rdata, b0.imem_resp, b0.dmem_rdata, b0.dmem_resp};
    assign act1 = {b1.imem_req_ack, b1.dmem_req_ack, b1.port_req, b1.port_cmd, b1.port_width,
                   b1.port_addr, b1.port_wdata, b1.imem_rdata, b1.imem_resp, b1.dmem_rdata, b1.dmem_resp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int winner(input int k);
        if (imem_req && dmem_req) return (k == 1) ? 1 : 1 - last_m[k];
        return dmem_req ? 1 : 0;
    endfunction

    function automatic out_t expect_out(input int k);
        out_t e;
        int   w;
        bit   busy;
        bit   open;
        e    = '0;
        w    = winner(k);
        busy = own_m[k] >= 0;
        open = !busy || port_resp == OK;
        e.port_req     = open && ((w == 1) ? dmem_req : imem_req);
        e.imem_req_ack = open && w == 0 && port_req_ack;
        e.dmem_req_ack = open && w == 1 && port_req_ack;
        if (w == 1) begin
            e.port_cmd = dmem_cmd;  e.port_width = dmem_width;
            e.port_addr = dmem_addr; e.port_wdata = dmem_wdata;
        end else begin
            e.port_cmd = 1'b0;      e.port_width = 2'b10;
            e.port_addr = imem_addr; e.port_wdata = '0;
        end
        if (busy && own_m[k] == 0) begin
            e.imem_resp = port_resp; e.imem_rdata = port_rdata;
        end
        if (busy && own_m[k] == 1) begin
            e.dmem_resp = port_resp; e.dmem_rdata = port_rdata;
        end
        return e;
    endfunction

    out_t mdl_e;
    int   mdl_w;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_m  = '{-1, -1};
            last_m = '{1, 1};
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                mdl_e = expect_out(k);
                mdl_w = winner(k);
                if (own_m[k] >= 0 && port_resp != NRDY) own_m[k] = -1;
                if (mdl_e.port_req && port_req_ack) begin
                    own_m[k]  = mdl_w;
                    last_m[k] = mdl_w;
                end
            end
        end
    end

    out_t cmp_e, cmp_a;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            cmp_e = expect_out(k);
            cmp_a = (k == 0) ? act0 : act1;
            check($sformatf("dut%0d c%0d handshake", k, cyc),
                  128'({cmp_a.imem_req_ack, cmp_a.dmem_req_ack, cmp_a.port_req}),
                  128'({cmp_e.imem_req_ack, cmp_e.dmem_req_ack, cmp_e.port_req}));
            check($sformatf("dut%0d c%0d port", k, cyc),
                  128'({cmp_a.port_cmd, cmp_a.port_width, cmp_a.port_addr, cmp_a.port_wdata}),
                  128'({cmp_e.port_cmd, cmp_e.port_width, cmp_e.port_addr, cmp_e.port_wdata}));
            check($sformatf("dut%0d c%0d resp", k, cyc),
                  128'({cmp_a.imem_rdata, cmp_a.imem_resp, cmp_a.dmem_rdata, cmp_a.dmem_resp}),
                  128'({cmp_e.imem_rdata, cmp_e.imem_resp, cmp_e.dmem_rdata, cmp_e.dmem_resp}));
        end
    end

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dc, input logic [1:0] dw,
                         input logic [31:0] da, input logic [31:0] dwd,
                         input logic ack, input logic [1:0] rs, input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst_n = r;       imem_req = ir;   imem_addr = ia;
        dmem_req = dr;   dmem_cmd = dc;   dmem_width = dw;
        dmem_addr = da;  dmem_wdata = dwd;
        port_req_ack = ack; port_resp = rs; port_rdata = rd;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; imem_req = 1'b0; imem_addr = '0; dmem_req = 1'b0; dmem_cmd = 1'b0;
        dmem_width = '0; dmem_addr = '0; dmem_wdata = '0;
        port_req_ack = 1'b0; port_resp = NRDY; port_rdata = '0;
        @(negedge clk);
        check("reset port_req", 128'(b0.port_req), 128'(0));
        check("reset imem_resp", 128'(b0.imem_resp), 128'(NRDY));

        // Single imem read at 0x100
        drive(1, 1, 32'h100, 0, 0, 0, 0, 0, 1, NRDY, 0);
        check("t1 imem_req_ack", 128'(b0.imem_req_ack), 128'(1));
        check("t1 port_addr", 128'(b0.port_addr), 128'(32'h100));
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, NRDY, 0);
        check("t1 stall imem_resp", 128'(b0.imem_resp), 128'(NRDY));
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, OK, 32'hDEADBEEF);
        check("t1 imem_resp", 128'(b0.imem_resp), 128'(OK));
        check("t1 imem_rdata", 128'(b0.imem_rdata), 128'(32'hDEADBEEF));
        check("t1 dmem_resp", 128'(b0.dmem_resp), 128'(NRDY));
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, OK, 32'h55);
        check("t1 addr ignores resp", 128'(b0.imem_resp), 128'(NRDY));

        // Both masters request every cycle from reset
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, NRDY, 0);
        drive(1, 1, 32'h200, 1, 0, 2'b10, 32'h1000, 0, 1, NRDY, 0);
        check("t2 c0 imem wins", 128'({b0.imem_req_ack, b0.dmem_req_ack}), 128'(2'b10));
        check("t2 c0 prio dmem", 128'({b1.imem_req_ack, b1.dmem_req_ack}), 128'(2'b01));
        drive(1, 1, 32'h204, 1, 0, 2'b10, 32'h1004, 0, 1, OK, 32'h11);
        check("t2 c1 dmem wins", 128'({b0.imem_req_ack, b0.dmem_req_ack}), 128'(2'b01));
        check("t2 c1 imem data", 128'({b0.imem_resp, b0.imem_rdata}), 128'({OK, 32'h11}));
        check("t2 c1 dmem quiet", 128'(b0.dmem_resp), 128'(NRDY));
        check("t2 c1 prio dmem data", 128'({b1.dmem_resp, b1.dmem_req_ack}), 128'({OK, 1'b1}));
        drive(1, 1, 32'h208, 1, 0, 2'b10, 32'h1008, 0, 1, OK, 32'h22);
        check("t2 c2 imem wins", 128'({b0.imem_req_ack, b0.dmem_req_ack}), 128'(2'b10));
        check("t2 c2 dmem data", 128'({b0.dmem_resp, b0.dmem_rdata}), 128'({OK, 32'h22}));
        drive(1, 1, 32'h20C, 1, 0, 2'b10, 32'h100C, 0, 1, OK, 32'h33);
        check("t2 c3 dmem wins", 128'({b0.imem_req_ack, b0.dmem_req_ack}), 128'(2'b01));
        drive(1, 1, 32'h210, 1, 0, 2'b10, 32'h1010, 0, 1, OK, 32'h44);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, OK, 32'h66);

        // dmem HWORD write stalled 3 cycles while imem also requests
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h300, 1, 1, 2'b01, 32'h2000, 32'h12345678, 0, NRDY, 0);
            check($sformatf("t3 stall%0d fields", i),
                  128'({b0.port_req, b0.port_cmd, b0.port_width, b0.port_addr, b0.port_wdata}),
                  128'({1'b1, 1'b1, 2'b01, 32'h2000, 32'h12345678}));
            check($sformatf("t3 stall%0d acks", i),
                  128'({b0.imem_req_ack, b0.dmem_req_ack}), 128'(2'b00));
        end
        drive(1, 1, 32'h300, 1, 1, 2'b01, 32'h2000, 32'h12345678, 1, NRDY, 0);
        check("t3 ack", 128'({b0.imem_req_ack, b0.dmem_req_ack}), 128'(2'b01));
        drive(1, 1, 32'h300, 0, 0, 0, 0, 0, 1, OK, 0);
        check("t3 write done + imem accept", 128'({b0.dmem_resp, b0.imem_req_ack}), 128'({OK, 1'b1}));

        // Pipelined: imem RDY_OK in the same cycle as a dmem accept
        drive(1, 0, 0, 1, 0, 2'b10, 32'h3000, 0, 1, OK, 32'hA5A5);
        check("t4 imem ok", 128'({b0.imem_resp, b0.imem_rdata}), 128'({OK, 32'hA5A5}));
        check("t4 dmem ack", 128'(b0.dmem_req_ack), 128'(1));
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, OK, 32'h5A5A);
        check("t4 dmem ok", 128'({b0.dmem_resp, b0.dmem_rdata, b0.imem_resp}),
              128'({OK, 32'h5A5A, NRDY}));

        // RDY_ER for dmem while imem requests
        drive(1, 0, 0, 1, 0, 2'b10, 32'h40, 0, 1, NRDY, 0);
        drive(1, 1, 32'h44, 0, 0, 0, 0, 0, 1, ER, 32'hBAD);
        check("t5 dmem err", 128'({b0.dmem_resp, b0.port_req, b0.imem_req_ack}),
              128'({ER, 1'b0, 1'b0}));
        drive(1, 1, 32'h44, 0, 0, 0, 0, 0, 1, NRDY, 0);
        check("t5 imem accept", 128'({b0.port_req, b0.imem_req_ack}), 128'(2'b11));

        // Reset while imem data phase is outstanding
        drive(1, 1, 32'h48, 0, 0, 0, 0, 0, 0, NRDY, 0);
        check("t6 stall no req", 128'(b0.port_req), 128'(0));
        drive(0, 1, 32'h48, 0, 0, 0, 0, 0, 0, OK, 32'h77);
        check("t6 reset resp", 128'({b0.imem_resp, b0.imem_rdata, b0.dmem_resp}),
              128'({NRDY, 32'h0, NRDY}));
        check("t6 reset port_req", 128'(b0.port_req), 128'(1));
        drive(1, 1, 32'h50, 1, 0, 2'b10, 32'h60, 0, 1, NRDY, 0);
        check("t6 imem first tie", 128'({b0.imem_req_ack, b0.dmem_req_ack}), 128'(2'b10));
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, OK, 32'h99);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, NRDY, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/scr1_imem_dmem_arbiter.md
Name: scr1_imem_dmem_arbiter

Overview:
- Shares one SCR1 memory-interface slave port between the core instruction port (imem, read-only) and data port (dmem, read/write).
- Sits between the core and a single-ported memory or bridge, e.g. in front of a shared TCM/AHB bridge downstream of the imem and dmem routers.
- Round-robin arbitration; supports pipelined back-to-back transfers: a new address phase may be accepted in the same cycle as the current RDY_OK response.

Parameters:
- AWIDTH, 32, address width of all ports.
- DWIDTH, 32, data width of all ports.
- DMEM_PRIO, 0, 0 = round-robin on contention; 1 = dmem always wins contention.

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_ack  output  1  imem request accepted.
- imem_req  input  1  imem request.
- imem_addr  input  AWIDTH  imem address.
- imem_rdata  output  DWIDTH  imem read data.
- imem_resp  output  2  imem response, type_scr1_mem_resp_e.
- dmem_req_ack  output  1  dmem request accepted.
- dmem_req  input  1  dmem request.
- dmem_cmd  input  1  SCR1_MEM_CMD_RD/WR.
- dmem_width  input  2  type_scr1_mem_width_e.
- dmem_addr  input  AWIDTH  dmem address.
- dmem_wdata  input  DWIDTH  dmem write data.
- dmem_rdata  output  DWIDTH  dmem read data.
- dmem_resp  output  2  dmem response.
- port_req_ack  input  1  slave accepted request.
- port_req  output  1  request to slave.
- port_cmd  output  1  command to slave.
- port_width  output  2  access width to slave.
- port_addr  output  AWIDTH  address to slave.
- port_wdata  output  DWIDTH  write data to slave.
- port_rdata  input  DWIDTH  slave read data.
- port_resp  input  2  slave response.

Behaviour:
- State: fsm {ADDR, DATA}, owner (0 = imem, 1 = dmem; the master whose data phase is outstanding), last_gnt (last accepted master).
- Reset: fsm = ADDR, owner = 0, last_gnt = 1, so imem wins the first tie. Reset asserted mid-transfer drops the outstanding transfer silently.
- Address window open: fsm == ADDR, or fsm == DATA with port_resp == RDY_OK. Otherwise imem_req_ack = dmem_req_ack = port_req = 0.
- Grant (combinational, evaluated only while the window is open):
  - Only one master requesting: that master.
  - Both requesting: DMEM_PRIO = 1 gives dmem; otherwise the master != last_gnt.
  - The grant stays stable while a request is stalled, because last_gnt changes only on accept.
- Window open: port_req = gnt master's req; gnt master's req_ack = port_req_ack; other req_ack = 0.
- Port muxing:
  - imem granted: port_cmd = RD, port_width = WORD, port_addr = imem_addr, port_wdata = 0.
  - dmem granted: dmem fields pass through.
  - No requester: imem values are driven, with port_req = 0.
- Accept means port_req & port_req_ack. On accept: fsm = DATA, owner = gnt, last_gnt = gnt.
- DATA with port_resp NOTRDY: hold all state; no new request issued.
- DATA with RDY_OK: response delivered to owner. If accept occurs in the same cycle, stay in DATA with the new owner; else go to ADDR.
- DATA with RDY_ER: response delivered to owner; go to ADDR. No accept in that cycle because the window is closed.
- Response routing: owner's resp = port_resp and rdata = port_rdata while fsm == DATA. Non-owner, or fsm == ADDR: resp = NOTRDY, rdata = 0.
- Latency: zero added cycles. Requests and responses pass combinationally; the slave's latency is preserved.
- port_resp is ignored in ADDR.

Test Plan:
- Single imem read at 0x100 with slave ack in cycle 0 and RDY_OK data 0xDEADBEEF in cycle 2 -> imem_req_ack in cycle 0, imem_resp RDY_OK with rdata 0xDEADBEEF in cycle 2, dmem_resp NOTRDY throughout.
- Both masters request every cycle from reset, slave acks immediately and returns RDY_OK next cycle -> accepts alternate imem, dmem, imem, dmem; each response lands only on its owner. With DMEM_PRIO = 1 -> dmem wins every contended cycle.
- dmem write of 0x12345678 to 0x2000, width HWORD, slave stalls port_req_ack for 3 cycles while imem also requests -> port fields constant for all 3 stall cycles, grant does not switch, dmem_req_ack only in the ack cycle.
- Pipelined: RDY_OK for imem in the same cycle as a dmem accept -> imem gets RDY_OK, fsm stays DATA, owner becomes dmem, and the next RDY_OK goes to dmem.
- RDY_ER response for dmem while imem is requesting -> dmem_resp RDY_ER, no port_req that cycle, imem is accepted the following cycle from ADDR.
- rst_n low while in DATA with imem requesting -> next cycle fsm = ADDR, both responses NOTRDY, port_req follows imem_req, and imem wins the first tie after release.
